// File: rtl/bck_ext_loop_ctrl.sv
// Backward-extension loop-control stage: i/j nested-loop bookkeeping per token,
// valid/ready handshake with a 2-entry (output + skid) buffer and saturating event counters.
module bck_ext_loop_ctrl #(
    parameter int          SIZE_W = 7,
    parameter int          SIDE_W = 170,
    parameter int          PEND_W = 256,
    parameter int          CNT_W  = 32,
    parameter logic [5:0]  ST_INI = 6'd1,
    parameter logic [5:0]  ST_RUN = 6'd2,
    parameter logic [5:0]  ST_BUB = 6'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_status,
    input  logic [SIDE_W-1:0] in_side,
    input  logic [PEND_W-1:0] in_pend,
    input  logic [7:0]        in_out_c,
    input  logic [SIZE_W-1:0] in_fwd_size,
    input  logic [SIZE_W-1:0] in_size,
    input  logic [SIZE_W-1:0] in_last_size,
    input  logic [SIZE_W-1:0] in_wr_addr,
    input  logic [SIZE_W-1:0] in_i,
    input  logic [SIZE_W-1:0] in_j,
    input  logic              in_iter_bnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_status,
    output logic [SIDE_W-1:0] out_side,
    output logic [PEND_W-1:0] out_pend,
    output logic [7:0]        out_out_c,
    output logic [SIZE_W-1:0] out_fwd_size,
    output logic [SIZE_W-1:0] out_size,
    output logic [SIZE_W-1:0] out_last_size,
    output logic [SIZE_W-1:0] out_wr_addr,
    output logic [SIZE_W-1:0] out_i,
    output logic [SIZE_W-1:0] out_j,
    output logic              out_iter_bnd,
    output logic              out_finish,
    output logic              out_last_one,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  finish_cnt,
    output logic [CNT_W-1:0]  iter_cnt
);

    localparam logic [SIZE_W-1:0] SZ_ZERO = {SIZE_W{1'b0}};
    localparam logic [SIZE_W-1:0] SZ_ONE  = {{(SIZE_W-1){1'b0}}, 1'b1};

    // iter_evt travels with the token so the loop-exit counter can be bumped on delivery.
    typedef struct packed {
        logic [5:0]        status;
        logic [SIDE_W-1:0] side;
        logic [PEND_W-1:0] pend;
        logic [7:0]        out_c;
        logic [SIZE_W-1:0] fwd_size;
        logic [SIZE_W-1:0] size;
        logic [SIZE_W-1:0] last_size;
        logic [SIZE_W-1:0] wr_addr;
        logic [SIZE_W-1:0] i;
        logic [SIZE_W-1:0] j;
        logic              iter_bnd;
        logic              finish;
        logic              last_one;
        logic              iter_evt;
    } tok_t;

    function automatic tok_t bubble_tok();
        tok_t t;
        t        = {$bits(tok_t){1'b0}};
        t.status = ST_BUB;
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        if (inc && (c != {CNT_W{1'b1}})) begin
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return c;
        end
    endfunction

    tok_t              new_tok_s;
    tok_t              out_tok_r;
    tok_t              out_tok_n;
    tok_t              skid_tok_r;
    tok_t              skid_tok_n;
    logic              out_vld_r;
    logic              out_vld_n;
    logic              skid_vld_r;
    logic              skid_vld_n;
    logic              in_rdy_r;
    logic              accept_s;
    logic              deliver_s;
    logic              jb_s;
    logic [SIZE_W-1:0] fwd_m1_s;
    logic [CNT_W-1:0]  finish_cnt_r;
    logic [CNT_W-1:0]  iter_cnt_r;

    // A zero last_size must never bound, so it is excluded before the j compare.
    assign jb_s      = (in_last_size != SZ_ZERO) && (in_j == (in_last_size - SZ_ONE));
    assign fwd_m1_s  = (in_fwd_size == SZ_ZERO) ? SZ_ZERO : (in_fwd_size - SZ_ONE);
    assign accept_s  = in_valid & in_rdy_r;
    assign deliver_s = out_vld_r & out_ready;

    // Loop-index update applied to the incoming token.
    always_comb begin
        new_tok_s = bubble_tok();
        case (in_status)
            ST_INI: begin
                new_tok_s.status    = ST_INI;
                new_tok_s.side      = in_side;
                new_tok_s.fwd_size  = in_fwd_size;
                new_tok_s.size      = in_size;
                new_tok_s.last_size = in_last_size;
                new_tok_s.wr_addr   = in_wr_addr;
                new_tok_s.i         = in_i;
                new_tok_s.j         = in_j;
                new_tok_s.iter_bnd  = in_iter_bnd;
            end
            ST_RUN: begin
                new_tok_s.status    = ST_RUN;
                new_tok_s.side      = in_side;
                new_tok_s.pend      = in_pend;
                new_tok_s.out_c     = in_out_c;
                new_tok_s.fwd_size  = in_fwd_size;
                new_tok_s.finish    = jb_s && (in_size == SZ_ZERO);
                new_tok_s.last_one  = jb_s && (in_size == SZ_ONE);
                new_tok_s.iter_bnd  = in_iter_bnd || (jb_s && (in_i == SZ_ZERO));
                new_tok_s.iter_evt  = !in_iter_bnd && jb_s && (in_i == SZ_ZERO);
                new_tok_s.j         = jb_s ? SZ_ZERO : (in_j + SZ_ONE);
                new_tok_s.wr_addr   = jb_s ? fwd_m1_s : in_wr_addr;
                new_tok_s.last_size = jb_s ? in_size : in_last_size;
                new_tok_s.size      = jb_s ? SZ_ZERO : in_size;
                if (in_iter_bnd) begin
                    new_tok_s.i = SZ_ZERO;
                end else if (jb_s && (in_i != SZ_ZERO)) begin
                    new_tok_s.i = in_i - SZ_ONE;
                end else begin
                    new_tok_s.i = in_i;
                end
            end
            default: begin
                new_tok_s = bubble_tok();
            end
        endcase
    end

    // Output/skid steering; the skid is only ever full while the output register is full.
    always_comb begin
        out_vld_n  = out_vld_r;
        out_tok_n  = out_tok_r;
        skid_vld_n = skid_vld_r;
        skid_tok_n = skid_tok_r;
        if (!out_vld_r) begin
            if (accept_s) begin
                out_vld_n = 1'b1;
                out_tok_n = new_tok_s;
            end else begin
                out_vld_n = 1'b0;
            end
        end else if (deliver_s) begin
            if (skid_vld_r) begin
                out_tok_n  = skid_tok_r;
                skid_vld_n = 1'b0;
            end else if (accept_s) begin
                out_tok_n = new_tok_s;
            end else begin
                out_vld_n = 1'b0;
                out_tok_n = bubble_tok();
            end
        end else if (accept_s) begin
            skid_vld_n = 1'b1;
            skid_tok_n = new_tok_s;
        end else begin
            skid_vld_n = skid_vld_r;
        end
    end

    // Pipeline registers and counters; reset flushes any held tokens.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld_r    <= 1'b0;
            skid_vld_r   <= 1'b0;
            in_rdy_r     <= 1'b1;
            out_tok_r    <= bubble_tok();
            skid_tok_r   <= {$bits(tok_t){1'b0}};
            finish_cnt_r <= {CNT_W{1'b0}};
            iter_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            out_vld_r  <= out_vld_n;
            skid_vld_r <= skid_vld_n;
            in_rdy_r   <= !skid_vld_n;
            out_tok_r  <= out_tok_n;
            skid_tok_r <= skid_tok_n;
            if (cnt_clr) begin
                finish_cnt_r <= {CNT_W{1'b0}};
                iter_cnt_r   <= {CNT_W{1'b0}};
            end else begin
                finish_cnt_r <= sat_inc(finish_cnt_r, deliver_s & out_tok_r.finish);
                iter_cnt_r   <= sat_inc(iter_cnt_r, deliver_s & out_tok_r.iter_evt);
            end
        end
    end

    assign in_ready      = in_rdy_r;
    assign out_valid     = out_vld_r;
    assign out_status    = out_tok_r.status;
    assign out_side      = out_tok_r.side;
    assign out_pend      = out_tok_r.pend;
    assign out_out_c     = out_tok_r.out_c;
    assign out_fwd_size  = out_tok_r.fwd_size;
    assign out_size      = out_tok_r.size;
    assign out_last_size = out_tok_r.last_size;
    assign out_wr_addr   = out_tok_r.wr_addr;
    assign out_i         = out_tok_r.i;
    assign out_j         = out_tok_r.j;
    assign out_iter_bnd  = out_tok_r.iter_bnd;
    assign out_finish    = out_tok_r.finish;
    assign out_last_one  = out_tok_r.last_one;
    assign finish_cnt    = finish_cnt_r;
    assign iter_cnt      = iter_cnt_r;

endmodule

// File: tb/tb_bck_ext_loop_ctrl.sv
// Scoreboard bench for bck_ext_loop_ctrl: directed scenarios plus a long randomized run,
// expected tokens come from a spec-level model and are popped by an independent monitor.
module tb_bck_ext_loop_ctrl;

    localparam logic [5:0] ST_INI = 6'd1;
    localparam logic [5:0] ST_RUN = 6'd2;
    localparam logic [5:0] ST_BUB = 6'd0;

    typedef struct packed {
        logic [5:0]   st;
        logic [169:0] side;
        logic [255:0] pend;
        logic [7:0]   oc;
        logic [6:0]   fwd;
        logic [6:0]   size;
        logic [6:0]   last;
        logic [6:0]   wr;
        logic [6:0]   i;
        logic [6:0]   j;
        logic         ib;
        logic         fin;
        logic         lo;
        logic         evt;
    } tok_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic cnt_clr = 1'b0;
    tok_t drv = '0;

    logic         in_ready;
    logic         out_valid;
    logic [5:0]   out_status;
    logic [169:0] out_side;
    logic [255:0] out_pend;
    logic [7:0]   out_out_c;
    logic [6:0]   out_fwd_size, out_size, out_last_size, out_wr_addr, out_i, out_j;
    logic         out_iter_bnd, out_finish, out_last_one;
    logic [31:0]  finish_cnt, iter_cnt;

    int   n_chk = 0;
    int   n_pass = 0;
    tok_t sbq[$];
    int   mf = 0;
    int   mi = 0;

    always #5 clk = ~clk;

    bck_ext_loop_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_status(drv.st), .in_side(drv.side), .in_pend(drv.pend), .in_out_c(drv.oc),
        .in_fwd_size(drv.fwd), .in_size(drv.size), .in_last_size(drv.last),
        .in_wr_addr(drv.wr), .in_i(drv.i), .in_j(drv.j), .in_iter_bnd(drv.ib),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_status(out_status), .out_side(out_side), .out_pend(out_pend), .out_out_c(out_out_c),
        .out_fwd_size(out_fwd_size), .out_size(out_size), .out_last_size(out_last_size),
        .out_wr_addr(out_wr_addr), .out_i(out_i), .out_j(out_j), .out_iter_bnd(out_iter_bnd),
        .out_finish(out_finish), .out_last_one(out_last_one),
        .cnt_clr(cnt_clr), .finish_cnt(finish_cnt), .iter_cnt(iter_cnt)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] rw();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic tok_t mk(input logic [5:0] st, input int last, input int j, input int i,
                                input int size, input int fwd, input int wr, input bit ib);
        tok_t t;
        logic [255:0] w;
        t = '0;
        w = rw();
        t.st = st; t.side = w[169:0]; t.pend = rw(); t.oc = 8'($urandom);
        t.last = 7'(last); t.j = 7'(j); t.i = 7'(i); t.size = 7'(size);
        t.fwd = 7'(fwd); t.wr = 7'(wr); t.ib = ib;
        return t;
    endfunction

    // Reference behaviour written straight from the token rules using integer arithmetic.
    function automatic tok_t model(input tok_t t);
        tok_t e;
        bit   jb;
        e = '0;
        if (t.st == ST_INI) begin
            e = t;
            e.pend = '0; e.oc = '0; e.fin = 1'b0; e.lo = 1'b0; e.evt = 1'b0;
        end else if (t.st == ST_RUN) begin
            jb = (t.last != 0) && (int'(t.j) == int'(t.last) - 1);
            e.st = ST_RUN; e.side = t.side; e.pend = t.pend; e.oc = t.oc; e.fwd = t.fwd;
            e.fin  = jb && (t.size == 0);
            e.lo   = jb && (t.size == 1);
            e.ib   = t.ib || (jb && t.i == 0);
            e.evt  = !t.ib && jb && (t.i == 0);
            e.i    = t.ib ? 7'd0 : 7'((jb && t.i > 0) ? int'(t.i) - 1 : int'(t.i));
            e.j    = jb ? 7'd0 : 7'((int'(t.j) + 1) % 128);
            e.wr   = jb ? 7'((t.fwd == 0) ? 0 : int'(t.fwd) - 1) : t.wr;
            e.last = jb ? t.size : t.last;
            e.size = jb ? 7'd0 : t.size;
        end else begin
            e.st = ST_BUB;
        end
        return e;
    endfunction

    function automatic tok_t rand_tok();
        tok_t t;
        int   r;
        r = $urandom_range(0, 9);
        t = mk(6'd0, $urandom_range(0, 6), 0, $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 127),
               $urandom_range(0, 127), $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) t.last = 7'($urandom);
        if ($urandom_range(0, 7) == 0) t.size = 7'($urandom);
        if ($urandom_range(0, 1) == 1) t.j = t.last - 7'd1;
        else t.j = 7'($urandom);
        if (r < 2) t.st = ST_INI;
        else if (r < 8) t.st = ST_RUN;
        else if (r == 8) t.st = 6'($urandom_range(3, 63));
        else t.st = ST_BUB;
        return t;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the token was taken.
    task automatic send(input tok_t t);
        int b;
        drv = t;
        in_valid = 1'b1;
        b = 0;
        @(negedge clk);
        while (!in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: counters, idle status, and in-order token comparison against the scoreboard.
    always @(negedge clk) begin
        tok_t e;
        tok_t a;
        if (!rst) begin
            sbq.delete();
            mf = 0;
            mi = 0;
        end else begin
            chk("finish_cnt", finish_cnt, mf);
            chk("iter_cnt", iter_cnt, mi);
            if (!out_valid) chk("idle_status", out_status, ST_BUB);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("out_without_token", out_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    a.st = out_status; a.side = out_side; a.pend = out_pend; a.oc = out_out_c;
                    a.fwd = out_fwd_size; a.size = out_size; a.last = out_last_size;
                    a.wr = out_wr_addr; a.i = out_i; a.j = out_j; a.ib = out_iter_bnd;
                    a.fin = out_finish; a.lo = out_last_one; a.evt = e.evt;
                    chk("token", a, e);
                    if (e.fin) mf++;
                    if (e.evt) mi++;
                end
            end
            if (cnt_clr) begin
                mf = 0;
                mi = 0;
            end
            if (in_valid && in_ready) sbq.push_back(model(drv));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tok_t tk[3];
        int   nacc;
        int   sent;
        bit   have;
        tok_t cur;

        idle(3);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_fields", {out_status, out_j, out_i, out_size, out_wr_addr, out_finish}, 0);
        @(posedge clk); #1;

        // Basic bound with i decrement and 1-cycle latency
        out_ready = 1'b1;
        send(mk(ST_RUN, 4, 3, 5, 3, 20, 7, 1'b0));
        @(negedge clk);
        chk("run_basic", {out_valid, out_i, out_j, out_wr_addr, out_last_size, out_size, out_finish},
            {1'b1, 7'd4, 7'd0, 7'd19, 7'd3, 7'd0, 1'b0});
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;

        // Loop exit at i==0: last_one then finish
        send(mk(ST_RUN, 4, 3, 0, 1, 10, 2, 1'b0));
        @(negedge clk);
        chk("iexit_flags", {out_iter_bnd, out_last_one, out_finish, out_wr_addr}, {1'b1, 1'b1, 1'b0, 7'd9});
        @(posedge clk); #1;
        chk("iexit_iter_cnt", iter_cnt, 1);
        send(mk(ST_RUN, 4, 3, 0, 0, 10, 2, 1'b0));
        @(negedge clk);
        chk("finish_flag", {out_finish, out_last_one}, {1'b1, 1'b0});
        @(posedge clk); #1;
        chk("finish_cnt_dir", {finish_cnt, iter_cnt}, {32'd1, 32'd2});

        // Edge cases
        send(mk(ST_RUN, 0, 127, 2, 5, 30, 11, 1'b0));
        @(negedge clk);
        chk("zero_last_wrap", {out_j, out_last_size, out_size, out_i, out_wr_addr, out_finish},
            {7'd0, 7'd0, 7'd5, 7'd2, 7'd11, 1'b0});
        @(posedge clk); #1;
        send(mk(ST_RUN, 2, 1, 3, 4, 0, 9, 1'b0));
        @(negedge clk);
        chk("fwd_zero", {out_wr_addr, out_last_size, out_size, out_i, out_j}, {7'd0, 7'd4, 7'd0, 7'd2, 7'd0});
        @(posedge clk); #1;
        send(mk(ST_RUN, 9, 2, 3, 4, 50, 9, 1'b1));
        @(negedge clk);
        chk("iter_bnd_in", {out_i, out_iter_bnd, out_j}, {7'd0, 1'b1, 7'd3});
        @(posedge clk); #1;
        tk[0] = mk(ST_INI, 4, 3, 0, 0, 12, 6, 1'b0);
        tk[0].pend[17] = 1'b1;
        tk[0].oc = 8'hab;
        send(tk[0]);
        @(negedge clk);
        chk("ini_zeroed", {out_status, out_pend, out_out_c, out_finish, out_j, out_wr_addr},
            {ST_INI, 256'd0, 8'd0, 1'b0, 7'd3, 7'd6});
        @(posedge clk); #1;
        send(mk(6'd5, 4, 3, 1, 2, 12, 6, 1'b1));
        @(negedge clk);
        chk("bubble", {out_valid, out_status, out_side, out_pend, out_out_c, out_j, out_i, out_size, out_iter_bnd},
            {1'b1, 6'd0, 170'd0, 256'd0, 8'd0, 7'd0, 7'd0, 7'd0, 1'b0});
        @(posedge clk); #1;

        // Backpressure: three offers, two fit
        idle(2);
        out_ready = 1'b0;
        tk[0] = mk(ST_RUN, 5, 1, 2, 3, 8, 1, 1'b0);
        tk[1] = mk(ST_INI, 5, 2, 2, 3, 8, 1, 1'b0);
        tk[2] = mk(ST_RUN, 3, 2, 1, 6, 8, 1, 1'b0);
        nacc = 0;
        for (int c = 0; c < 3; c++) begin
            drv = tk[nacc];
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) nacc++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", nacc, 2);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        send(tk[2]);
        idle(5);
        chk("bp_drained", sbq.size(), 0);

        // Reset with both entries full
        out_ready = 1'b0;
        send(mk(ST_RUN, 4, 3, 0, 0, 8, 1, 1'b0));
        send(mk(ST_RUN, 4, 3, 0, 1, 8, 1, 1'b0));
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_flush", {out_valid, in_ready, out_status, finish_cnt, iter_cnt},
            {1'b0, 1'b1, 6'd0, 32'd0, 32'd0});
        @(posedge clk); #1;

        // Clear wins over a same-cycle increment
        out_ready = 1'b1;
        send(mk(ST_RUN, 4, 3, 1, 0, 8, 1, 1'b0));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pre_clr_cnt", finish_cnt, 1);
        send(mk(ST_RUN, 4, 3, 1, 0, 8, 1, 1'b0));
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_priority", {finish_cnt, out_valid}, {32'd0, 1'b0});

        // Randomized traffic
        sent = 0;
        have = 1'b0;
        cur = '0;
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                cur = rand_tok();
                have = 1'b1;
            end
            drv = cur;
            in_valid = have;
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                have = 1'b0;
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("rand_sent", sent, 10000);
        chk("rand_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
